alu_32bit: RTL and testbench
============================

ALU_32BIT -- requirements
Module: alu_32bit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port list SHALL be:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous active-low reset; 0 = reset.
- ALUControl  input  6  operation select (encodings in REQ-006).
- A  input  32  operand A (shift source, branch test operand).
- B  input  32  operand B (shift amount in B[4:0]).
- ALUResult  output  32  registered result.
- Zero  output  1  registered flag.
REQ-003 The block SHALL have no parameters; data width is fixed at 32.

Function
REQ-004 The block SHALL compute result and flag combinationally from A, B and ALUControl.
REQ-005 The block SHALL register the result and flag on every rising Clk edge while Rst=1:
- no enable, no handshake.
- latency is exactly 1 cycle.
- inputs applied before edge N appear on the outputs after edge N.
REQ-006 Operation encodings SHALL be:
- 100000 ADD: A+B.
- 100010 SUB: A-B.
- 011000 MUL: low 32 bits of signed A*B.
- 100100 AND: A&B.
- 100101 OR: A|B.
- 100110 XOR: A^B.
- 100111 NOR: ~(A|B).
- 000000 SLL: A << B[4:0].
- 000010 SRL: A >> B[4:0], logical (zero fill).
- 000011 SRA: A >>> B[4:0], arithmetic (sign fill).
- 101010 SLT: 1 if signed A < signed B, else 0.
- 101011 SLTU: 1 if unsigned A < unsigned B, else 0.
- 000100 BEQ: result 0; Zero=1 iff A==B.
- 000101 BNE: result 0; Zero=1 iff A!=B.
- 000111 BGTZ: result 0; Zero=1 iff signed A > 0.
- 000110 BLEZ: result 0; Zero=1 iff signed A <= 0.
REQ-007 For every non-branch encoding, Zero SHALL be 1 iff the 32-bit result equals 0.
REQ-008 ADD, SUB and MUL SHALL wrap modulo 2^32 with no overflow flag or trap.
REQ-009 Shift amounts SHALL use only B[4:0]; B[31:5] SHALL be ignored.
REQ-010 Any undefined encoding SHALL produce ALUResult=0 and Zero=1.
REQ-011 BGTZ and BLEZ SHALL ignore B.
REQ-012 SLT and SLTU results SHALL be zero-extended to 32 bits.

Reset
REQ-013 While Rst=0, ALUResult SHALL be 0 and Zero SHALL be 0, asynchronously, independent of Clk.
REQ-014 On Rst deassertion, outputs SHALL hold their reset values until the first rising Clk edge with Rst=1.
REQ-015 Asserting Rst mid-operation SHALL discard the pending result; it SHALL not appear after reset release.

Verification
REQ-016 ADD: A=10, B=20, ALUControl=100000, one edge -> ALUResult=30, Zero=0.
REQ-017 SUB/MUL, one edge each:
- A=30, B=20, SUB -> ALUResult=10, Zero=0.
- A=3, B=7, MUL -> ALUResult=21.
- A=-3, B=7, MUL -> ALUResult=0xFFFFFFEB.
REQ-018 Logic/shift, one edge each:
- AND 15,8 -> 8.
- OR 5,3 -> 7.
- XOR 12,7 -> 11.
- SLL A=1, B=2 -> 4.
- SRL A=4, B=1 -> 2.
- SRA A=0x80000000, B=4 -> 0xF8000000.
REQ-019 Compare/branch, one edge each:
- SLT 10,20 -> 1.
- SLT A=-1, B=1 -> 1.
- SLTU A=-1, B=1 -> 0.
- BEQ 5,5 -> Zero=1.
- BNE 5,4 -> Zero=1.
- BGTZ A=1 -> Zero=1.
- BLEZ A=0 -> Zero=1.
- BLEZ A=0x80000000 -> Zero=1.
REQ-020 Latency/reset:
- Change inputs between edges -> outputs change only at the next rising edge.
- Drive Rst=0 asynchronously mid-cycle after an ADD 10+20 -> ALUResult=0 and Zero=0 immediately.
- Release Rst -> next edge shows the current inputs' result.
REQ-021 Undefined encoding 111111 with A=5, B=5 -> ALUResult=0, Zero=1.

Source files
------------

// File: rtl/alu_32bit.sv
// 32-bit ALU with a registered result and Zero flag (one cycle latency).
// Branch encodings drive Zero from the comparison and force the result to 0.
module alu_32bit (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [5:0]  ALUControl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] ALUResult,
    output logic        Zero
);

    typedef enum logic [5:0] {
        OpSll  = 6'b000000,
        OpSrl  = 6'b000010,
        OpSra  = 6'b000011,
        OpBeq  = 6'b000100,
        OpBne  = 6'b000101,
        OpBlez = 6'b000110,
        OpBgtz = 6'b000111,
        OpMul  = 6'b011000,
        OpAdd  = 6'b100000,
        OpSub  = 6'b100010,
        OpAnd  = 6'b100100,
        OpOr   = 6'b100101,
        OpXor  = 6'b100110,
        OpNor  = 6'b100111,
        OpSlt  = 6'b101010,
        OpSltu = 6'b101011
    } alu_op_e;

    logic [4:0]  shamt;
    logic [31:0] mul_lo;
    logic [31:0] sra_res;
    logic [31:0] result_d;
    logic [31:0] result_q;
    logic        zero_d;
    logic        zero_q;
    logic        branch_op;
    logic        branch_taken;

    assign shamt   = B[4:0];
    // The low half of a two's-complement product matches the unsigned one.
    assign mul_lo  = A * B;
    assign sra_res = $signed(A) >>> shamt;

    always_comb begin
        result_d     = 32'd0;
        branch_op    = 1'b0;
        branch_taken = 1'b0;
        case (ALUControl)
            OpAdd:  result_d = A + B;
            OpSub:  result_d = A - B;
            OpMul:  result_d = mul_lo;
            OpAnd:  result_d = A & B;
            OpOr:   result_d = A | B;
            OpXor:  result_d = A ^ B;
            OpNor:  result_d = ~(A | B);
            OpSll:  result_d = A << shamt;
            OpSrl:  result_d = A >> shamt;
            OpSra:  result_d = sra_res;
            OpSlt:  result_d = {31'd0, $signed(A) < $signed(B)};
            OpSltu: result_d = {31'd0, A < B};
            OpBeq: begin
                branch_op    = 1'b1;
                branch_taken = (A == B);
            end
            OpBne: begin
                branch_op    = 1'b1;
                branch_taken = (A != B);
            end
            OpBgtz: begin
                branch_op    = 1'b1;
                branch_taken = ($signed(A) > 32'sd0);
            end
            OpBlez: begin
                branch_op    = 1'b1;
                branch_taken = ($signed(A) <= 32'sd0);
            end
            default: result_d = 32'd0;
        endcase
    end

    // Undefined encodings leave result 0, so Zero naturally reads 1.
    assign zero_d = branch_op ? branch_taken : (result_d == 32'd0);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            result_q <= 32'd0;
            zero_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign ALUResult = result_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_32bit.sv
// Self-checking bench for alu_32bit: directed vectors, reset/latency cases,
// then randomized operations against an arithmetic reference model.
module tb_alu_32bit;

    logic        Clk;
    logic        Rst;
    logic [5:0]  ALUControl;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] ALUResult;
    logic        Zero;

    int n_checks = 0;
    int n_errors = 0;

    alu_32bit dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .ALUControl (ALUControl),
        .A          (A),
        .B          (B),
        .ALUResult  (ALUResult),
        .Zero       (Zero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, MUL = 6'b011000,
                           AND = 6'b100100, OR  = 6'b100101, XOR = 6'b100110,
                           NOR = 6'b100111, SLL = 6'b000000, SRL = 6'b000010,
                           SRA = 6'b000011, SLT = 6'b101010, SLTU = 6'b101011,
                           BEQ = 6'b000100, BNE = 6'b000101, BGTZ = 6'b000111,
                           BLEZ = 6'b000110;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on signed/unsigned views of the operands.
    function automatic void model(input logic [5:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] res,
                                  output logic zf);
        int          sa;
        int          sb;
        longint      prod;
        int unsigned sh;
        bit          is_branch;
        bit          taken;
        sa        = a;
        sb        = b;
        sh        = b % 32;
        res       = 0;
        is_branch = 0;
        taken     = 0;
        case (op)
            ADD:  res = a + b;
            SUB:  res = a - b;
            MUL: begin
                prod = longint'(sa) * longint'(sb);
                res  = prod[31:0];
            end
            AND:  res = a & b;
            OR:   res = a | b;
            XOR:  res = a ^ b;
            NOR:  res = ~(a | b);
            SLL:  res = a * (32'd1 << sh);
            SRL:  res = a / (33'd1 << sh);
            SRA:  res = (sa < 0) ? ~((~a) >> sh) : (a >> sh);
            SLT:  res = (sa < sb) ? 1 : 0;
            SLTU: res = (a < b) ? 1 : 0;
            BEQ:  begin is_branch = 1; taken = (a == b); end
            BNE:  begin is_branch = 1; taken = (a != b); end
            BGTZ: begin is_branch = 1; taken = (sa > 0); end
            BLEZ: begin is_branch = 1; taken = (sa <= 0); end
            default: res = 0;
        endcase
        zf = is_branch ? taken : (res == 0);
    endfunction

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        ALUControl = op;
        A          = a;
        B          = b;
        @(posedge Clk);
        #1;
    endtask

    task automatic run_vec(input string tag, input logic [5:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic        ez;
        drive(op, a, b);
        model(op, a, b, er, ez);
        check_eq({tag, ".res"}, ALUResult, er);
        check_eq({tag, ".zero"}, {31'd0, Zero}, {31'd0, ez});
    endtask

    task automatic run_exp(input string tag, input logic [5:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] er, input logic ez);
        drive(op, a, b);
        check_eq({tag, ".res"}, ALUResult, er);
        check_eq({tag, ".zero"}, {31'd0, Zero}, {31'd0, ez});
    endtask

    logic [5:0] ops [16] = '{ADD, SUB, MUL, AND, OR, XOR, NOR, SLL, SRL, SRA,
                             SLT, SLTU, BEQ, BNE, BGTZ, BLEZ};

    initial begin
        Rst        = 1'b0;
        ALUControl = ADD;
        A          = 32'd10;
        B          = 32'd20;
        #2;
        check_eq("reset.res", ALUResult, 32'd0);
        check_eq("reset.zero", {31'd0, Zero}, 32'd0);
        repeat (2) @(posedge Clk);
        #1;
        check_eq("reset_clk.res", ALUResult, 32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        check_eq("release_hold.res", ALUResult, 32'd0);
        check_eq("release_hold.zero", {31'd0, Zero}, 32'd0);

        // Hand-derived expectations.
        run_exp("add", ADD, 32'd10, 32'd20, 32'd30, 1'b0);
        run_exp("sub", SUB, 32'd30, 32'd20, 32'd10, 1'b0);
        run_exp("mul", MUL, 32'd3, 32'd7, 32'd21, 1'b0);
        run_exp("mul_neg", MUL, -32'sd3, 32'd7, 32'hFFFF_FFEB, 1'b0);
        run_exp("and", AND, 32'd15, 32'd8, 32'd8, 1'b0);
        run_exp("or", OR, 32'd5, 32'd3, 32'd7, 1'b0);
        run_exp("xor", XOR, 32'd12, 32'd7, 32'd11, 1'b0);
        run_exp("sll", SLL, 32'd1, 32'd2, 32'd4, 1'b0);
        run_exp("srl", SRL, 32'd4, 32'd1, 32'd2, 1'b0);
        run_exp("sra", SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
        run_exp("sll_bhi", SLL, 32'd1, 32'hFFFF_FFE3, 32'd8, 1'b0);
        run_exp("slt", SLT, 32'd10, 32'd20, 32'd1, 1'b0);
        run_exp("slt_neg", SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        run_exp("sltu_neg", SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        run_exp("beq", BEQ, 32'd5, 32'd5, 32'd0, 1'b1);
        run_exp("beq_ne", BEQ, 32'd5, 32'd4, 32'd0, 1'b0);
        run_exp("bne", BNE, 32'd5, 32'd4, 32'd0, 1'b1);
        run_exp("bgtz", BGTZ, 32'd1, 32'd0, 32'd0, 1'b1);
        run_exp("bgtz_neg", BGTZ, 32'h8000_0000, 32'd99, 32'd0, 1'b0);
        run_exp("blez0", BLEZ, 32'd0, 32'd7, 32'd0, 1'b1);
        run_exp("blez_min", BLEZ, 32'h8000_0000, 32'd0, 32'd0, 1'b1);
        run_exp("blez_pos", BLEZ, 32'd3, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_exp("add_wrap", ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        run_exp("undef", 6'b111111, 32'd5, 32'd5, 32'd0, 1'b1);

        // Inputs changed between edges must not reach the outputs early.
        run_exp("lat_a", ADD, 32'd1, 32'd2, 32'd3, 1'b0);
        @(negedge Clk);
        ALUControl = SUB;
        A          = 32'd9;
        B          = 32'd4;
        #1;
        check_eq("lat_hold", ALUResult, 32'd3);
        @(posedge Clk);
        #1;
        check_eq("lat_next", ALUResult, 32'd5);

        // Asynchronous reset mid-cycle discards the registered ADD result.
        run_exp("pre_rst", ADD, 32'd10, 32'd20, 32'd30, 1'b0);
        #2;
        Rst = 1'b0;
        #1;
        check_eq("async_rst.res", ALUResult, 32'd0);
        check_eq("async_rst.zero", {31'd0, Zero}, 32'd0);
        ALUControl = OR;
        A          = 32'h0000_00F0;
        B          = 32'h0000_000F;
        @(posedge Clk);
        #1;
        check_eq("rst_held.res", ALUResult, 32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        check_eq("rst_rel_hold", ALUResult, 32'd0);
        @(posedge Clk);
        #1;
        check_eq("rst_rel_first.res", ALUResult, 32'h0000_00FF);
        check_eq("rst_rel_first.zero", {31'd0, Zero}, 32'd0);

        // Randomized sweep, mostly defined encodings plus some raw codes.
        for (int i = 0; i < 400; i++) begin
            logic [5:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 15)];
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = a;
                1: a = 32'd0;
                2: a = 32'h8000_0000;
                default: ;
            endcase
            run_vec($sformatf("rnd%0d_op%06b", i, op), op, a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
